seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Parametrised time-multiplexed driver for a bank of NUM_DIGITS common-select seven-segment digits. Each digit has its own 4-bit hex code, its own decimal point and its own enable. Per-digit data is snapshotted at the start of each digit's slot, and each slot begins with an anti-ghosting blank interval. Brightness is set by an on-time input. The block sits between the display-data registers and the board segment/digit pins and replaces the fixed 8-digit, single-data scanner.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (>=1)
SCAN_DIV, 1000, clk cycles per digit slot (>=2)
BLANK_CYCLES, 2, dark cycles at the start of each slot (1 <= BLANK_CYCLES < SCAN_DIV)
DS_ACTIVE_LOW, 1, 1: digit select driven low when active
SEG_ACTIVE_LOW, 0, 1: segments and dp driven low when lit
CNT_W, $clog2(SCAN_DIV), derived width of the phase counter and on_cycles

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
d_in  in  4*NUM_DIGITS  hex code; digit i is d_in[4i+3:4i]
dp_in  in  NUM_DIGITS  decimal point request per digit
en  in  NUM_DIGITS  digit enable per digit
on_cycles  in  CNT_W  lit cycles per slot
seg  out  7  segment drive, order {g,f,e,d,c,b,a}
dp  out  1  decimal point drive
ds  out  NUM_DIGITS  digit selects; digit i drives ds[NUM_DIGITS-1-i]
frame_tick  out  1  one-cycle pulse at the start of each full scan

Behaviour:
- Reset (rst_n low at a clk edge): digit_idx=0, phase=0, snapshots cleared. Outputs: ds all inactive, seg and dp unlit, frame_tick=0. Reset asserted mid-slot has the same effect; the scan restarts at digit 0, phase 0.
- Scan counters: phase increments every cycle. At SCAN_DIV-1 phase wraps to 0 and digit_idx advances; digit_idx wraps from NUM_DIGITS-1 to 0.
- Snapshot: on the edge that ends phase 0, the block registers code=d_in[digit_idx], dpq=dp_in[digit_idx], enq=en[digit_idx] and on_eff=min(on_cycles, SCAN_DIV-BLANK_CYCLES). Input changes mid-slot do not affect the current slot.
- Active condition: enq && phase>=BLANK_CYCLES && (phase-BLANK_CYCLES)<on_eff. When on_cycles=0 the display stays dark.
- Outputs are registered. The output in cycle t reflects the state (digit_idx, phase) of cycle t-1, so latency is 1 cycle.
  - When active: ds has only bit NUM_DIGITS-1-digit_idx at the active level, seg=decode(code), dp=dpq.
  - Otherwise: all ds bits inactive, seg and dp unlit.
- Polarity is applied at the output registers:
  - ds inactive level = DS_ACTIVE_LOW.
  - seg/dp lit level = !SEG_ACTIVE_LOW.
- A disabled digit keeps its slot, so frame period and brightness stay uniform. Frame period is exactly NUM_DIGITS*SCAN_DIV cycles.
- Decode table ({g..a}, lit=1):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- frame_tick is registered and high for one cycle whenever the state is (digit 0, phase 0) following a wrap from (NUM_DIGITS-1, SCAN_DIV-1). It is never high in the first cycle after reset.
- Parameter violations fail at elaboration.

Decomposition:
- Package seg_pkg holds:
  - the 16 segment pattern constants;
  - seg_idx_t, 4-bit code type;
  - the lit/inactive polarity helper functions.
- One combinational sub-module, seg7_decode: 4-bit code in, 7-bit {g..a} out, table above.
- Counters, snapshot and output registers stay in seg_scan_ctrl.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, default polarities. Cycle 1 is the first cycle with rst_n high.
1. rst_n low for 5 cycles with random inputs -> ds=4'b1111, seg=0, dp=0, frame_tick=0 throughout.
2. d_in=16'h4321, dp_in=4'b0001, en=4'b1111, on_cycles=7 (saturates to 6):
   - cycles 4-9: ds=4'b0111, seg=06, dp=1.
   - cycles 10-11: dark.
   - cycles 12-17: ds=4'b1011, seg=5B, dp=0.
   - frame_tick high at cycles 33, 65, ...
3. en=4'b0101 -> ds never selects digits 1 or 3 (ds bits 2 and 0 stay 1); digit 2 is still lit in cycles 20-25; frame period stays 32.
4. on_cycles=3 -> each enabled digit is lit exactly 3 consecutive cycles per 8-cycle slot (phases 2-4); on_cycles=0 -> ds=4'b1111 forever.
5. Change d_in[3:0] from 1 to 8 during phase 4 of digit 0 -> seg stays 06 to the end of that slot; 7F first appears in the next frame's digit-0 slot. Sweep all 16 codes and check against the decode table.
6. Pull rst_n low for 1 cycle during phase 5 of digit 2 -> the next output is fully inactive; the scan restarts with digit 0 lit 3 cycles after rst_n returns high; the first frame_tick comes 32 cycles after restart.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types, segment patterns and pin-polarity helpers for the seven-segment scanner.
package seg_pkg;

  typedef logic [3:0] seg_idx_t;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, 1 = lit
  localparam logic [6:0] Seg0 = 7'h3F;
  localparam logic [6:0] Seg1 = 7'h06;
  localparam logic [6:0] Seg2 = 7'h5B;
  localparam logic [6:0] Seg3 = 7'h4F;
  localparam logic [6:0] Seg4 = 7'h66;
  localparam logic [6:0] Seg5 = 7'h6D;
  localparam logic [6:0] Seg6 = 7'h7D;
  localparam logic [6:0] Seg7 = 7'h07;
  localparam logic [6:0] Seg8 = 7'h7F;
  localparam logic [6:0] Seg9 = 7'h6F;
  localparam logic [6:0] SegA = 7'h77;
  localparam logic [6:0] SegB = 7'h7C;
  localparam logic [6:0] SegC = 7'h39;
  localparam logic [6:0] SegD = 7'h5E;
  localparam logic [6:0] SegE = 7'h79;
  localparam logic [6:0] SegF = 7'h71;

  // Map a logical "lit" segment vector to pin levels
  function automatic logic [6:0] seg_drive(input logic [6:0] lit, input bit active_low);
    return active_low ? ~lit : lit;
  endfunction

  // Map a logical "on" bit to its pin level; on=0 yields the inactive level
  function automatic logic pin_drive(input logic on, input bit active_low);
    return active_low ? ~on : on;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex code to seven-segment pattern, {g..a}, 1 = lit.
module seg7_decode
  import seg_pkg::*;
(
  input  seg_idx_t   code_i,
  output logic [6:0] seg_o
);

  // Table lookup
  always_comb begin
    seg_o = Seg0;
    case (code_i)
      4'h0: seg_o = Seg0;
      4'h1: seg_o = Seg1;
      4'h2: seg_o = Seg2;
      4'h3: seg_o = Seg3;
      4'h4: seg_o = Seg4;
      4'h5: seg_o = Seg5;
      4'h6: seg_o = Seg6;
      4'h7: seg_o = Seg7;
      4'h8: seg_o = Seg8;
      4'h9: seg_o = Seg9;
      4'hA: seg_o = SegA;
      4'hB: seg_o = SegB;
      4'hC: seg_o = SegC;
      4'hD: seg_o = SegD;
      4'hE: seg_o = SegE;
      4'hF: seg_o = SegF;
      default: seg_o = Seg0;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed driver for NUM_DIGITS seven-segment digits with per-slot snapshot,
// anti-ghosting blank interval and on-time brightness control.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned BLANK_CYCLES   = 2,
  parameter bit          DS_ACTIVE_LOW  = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter int unsigned CNT_W          = $clog2(SCAN_DIV)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] d_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   en,
  input  logic [CNT_W-1:0]        on_cycles,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   ds,
  output logic                    frame_tick
);

  localparam int unsigned DigW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] PhaseLast = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BlankC    = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] OnMax     = CNT_W'(SCAN_DIV - BLANK_CYCLES);
  localparam logic [DigW-1:0]  DigLast   = DigW'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1) begin : g_bad_num_digits
    $error("seg_scan_ctrl: NUM_DIGITS must be >= 1");
  end
  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("seg_scan_ctrl: SCAN_DIV must be >= 2");
  end
  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_blank
    $error("seg_scan_ctrl: BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < SCAN_DIV");
  end
  if (CNT_W < $clog2(SCAN_DIV)) begin : g_bad_cnt_w
    $error("seg_scan_ctrl: CNT_W too narrow for SCAN_DIV");
  end

  logic [DigW-1:0]       digit_q;
  logic [CNT_W-1:0]      phase_q;
  seg_idx_t              code_q;
  logic                  dpq_q;
  logic                  enq_q;
  logic [CNT_W-1:0]      on_eff_q;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] ds_q;
  logic                  frame_tick_q;

  logic                  wrap;
  logic                  last_digit;
  logic [CNT_W-1:0]      on_sat;
  logic                  active;
  logic [NUM_DIGITS-1:0] sel;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [NUM_DIGITS-1:0] ds_d;

  seg7_decode u_decode (
    .code_i (code_q),
    .seg_o  (dec_seg)
  );

  // Slot timing, lit window and next output levels
  always_comb begin
    wrap       = (phase_q == PhaseLast);
    last_digit = (digit_q == DigLast);
    on_sat     = (on_cycles > OnMax) ? OnMax : on_cycles;
    // Subtraction is only evaluated meaningfully once phase has passed the blank interval
    active     = enq_q && (phase_q >= BlankC) && ((phase_q - BlankC) < on_eff_q);
    sel        = '0;
    sel[DigLast - digit_q] = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      ds_d[i] = pin_drive(active && sel[i], DS_ACTIVE_LOW);
    end
    seg_d = seg_drive(active ? dec_seg : 7'h00, SEG_ACTIVE_LOW);
    dp_d  = pin_drive(active && dpq_q, SEG_ACTIVE_LOW);
  end

  // Phase and digit counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= '0;
      digit_q <= '0;
    end else begin
      phase_q <= wrap ? '0 : phase_q + 1'b1;
      if (wrap) begin
        digit_q <= last_digit ? '0 : digit_q + 1'b1;
      end
    end
  end

  // Per-slot snapshot of the current digit's inputs, taken as phase 0 ends
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_q   <= '0;
      dpq_q    <= 1'b0;
      enq_q    <= 1'b0;
      on_eff_q <= '0;
    end else if (phase_q == '0) begin
      code_q   <= d_in[{digit_q, 2'b00} +: 4];
      dpq_q    <= dp_in[digit_q];
      enq_q    <= en[digit_q];
      on_eff_q <= on_sat;
    end
  end

  // Registered pin drives and frame pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ds_q         <= {NUM_DIGITS{DS_ACTIVE_LOW}};
      seg_q        <= seg_drive(7'h00, SEG_ACTIVE_LOW);
      dp_q         <= SEG_ACTIVE_LOW;
      frame_tick_q <= 1'b0;
    end else begin
      ds_q         <= ds_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= wrap && last_digit;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign ds         = ds_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: 4 digits, 8-cycle slots, 2 blank cycles.
module tb_seg_scan_ctrl;

  localparam int unsigned NumDigits = 4;
  localparam int unsigned ScanDiv   = 8;
  localparam int unsigned Blank     = 2;
  localparam int unsigned CntW      = 3;

  logic        clk;
  logic        rst_n;
  logic [15:0] d_in;
  logic [3:0]  dp_in;
  logic [3:0]  en;
  logic [2:0]  on_cycles;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  ds;
  logic        frame_tick;

  int n_vec;
  int n_err;
  int cyc;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg_scan_ctrl #(
    .NUM_DIGITS     (NumDigits),
    .SCAN_DIV       (ScanDiv),
    .BLANK_CYCLES   (Blank),
    .DS_ACTIVE_LOW  (1'b1),
    .SEG_ACTIVE_LOW (1'b0),
    .CNT_W          (CntW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_in       (d_in),
    .dp_in      (dp_in),
    .en         (en),
    .on_cycles  (on_cycles),
    .seg        (seg),
    .dp         (dp),
    .ds         (ds),
    .frame_tick (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic check_dark(input string tag);
    check({tag, " ds"}, 32'(ds), 32'hF);
    check({tag, " seg"}, 32'(seg), 32'h00);
    check({tag, " dp"}, 32'(dp), 32'h0);
  endtask

  task automatic check_lit(input string tag, input logic [3:0] ds_e, input logic [6:0] seg_e,
                           input logic dp_e);
    check({tag, " ds"}, 32'(ds), 32'(ds_e));
    check({tag, " seg"}, 32'(seg), 32'(seg_e));
    check({tag, " dp"}, 32'(dp), 32'(dp_e));
  endtask

  // Hold reset n cycles with random inputs; leaves the bench in cycle 1
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      d_in      = 16'($urandom);
      dp_in     = 4'($urandom);
      en        = 4'($urandom);
      on_cycles = 3'($urandom);
      tick();
      check_dark($sformatf("rst c%0d", i));
      check($sformatf("rst ft c%0d", i), 32'(frame_tick), 32'h0);
    end
    rst_n = 1'b1;
    cyc   = 1;
  endtask

  initial begin
    logic [15:0] v;
    n_vec     = 0;
    n_err     = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    d_in      = '0;
    dp_in     = '0;
    en        = '0;
    on_cycles = '0;
    tick();

    // 1 + 2: reset, then basic scan with saturated on-time
    do_reset(5);
    d_in = 16'h4321; dp_in = 4'b0001; en = 4'b1111; on_cycles = 3'd7;
    check_dark("t2 c1");
    check("t2 ft c1", 32'(frame_tick), 32'h0);
    for (int c = 2; c <= 66; c++) begin
      tick();
      check($sformatf("t2 ft c%0d", c), 32'(frame_tick), 32'((c == 33) || (c == 65)));
      if (c == 3) check_dark($sformatf("t2 c%0d", c));
      if (c >= 4 && c <= 9) check_lit($sformatf("t2 c%0d", c), 4'b0111, 7'h06, 1'b1);
      if (c >= 10 && c <= 11) check_dark($sformatf("t2 c%0d", c));
      if (c >= 12 && c <= 17) check_lit($sformatf("t2 c%0d", c), 4'b1011, 7'h5B, 1'b0);
      if (c >= 20 && c <= 25) check_lit($sformatf("t2 c%0d", c), 4'b1101, 7'h4F, 1'b0);
      if (c >= 28 && c <= 33) check_lit($sformatf("t2 c%0d", c), 4'b1110, 7'h66, 1'b0);
    end

    // 3: digits 1 and 3 disabled keep their slots
    do_reset(2);
    d_in = 16'h4321; dp_in = 4'b0000; en = 4'b0101; on_cycles = 3'd7;
    for (int c = 2; c <= 66; c++) begin
      tick();
      check($sformatf("t3 ds20 c%0d", c), 32'({ds[2], ds[0]}), 32'h3);
      check($sformatf("t3 ft c%0d", c), 32'(frame_tick), 32'((c == 33) || (c == 65)));
      if (c >= 4 && c <= 9) check_lit($sformatf("t3 c%0d", c), 4'b0111, 7'h06, 1'b0);
      if (c >= 12 && c <= 17) check_dark($sformatf("t3 c%0d", c));
      if (c >= 20 && c <= 25) check_lit($sformatf("t3 c%0d", c), 4'b1101, 7'h4F, 1'b0);
    end

    // 4: on_cycles=3 gives three lit cycles (phases 2-4) per slot
    do_reset(2);
    d_in = 16'h4321; dp_in = 4'b0000; en = 4'b1111; on_cycles = 3'd3;
    for (int c = 2; c <= 40; c++) begin
      int dig;
      tick();
      dig = ((c - 4) / 8) % 4;
      if (c >= 4 && ((c - 4) % 8) < 3)
        check_lit($sformatf("t4 c%0d", c), ~(4'b1000 >> dig), seg_tab[dig + 1], 1'b0);
      else
        check_dark($sformatf("t4 c%0d", c));
    end
    // on_cycles=0 keeps the display dark
    do_reset(1);
    d_in = 16'h4321; dp_in = 4'b1111; en = 4'b1111; on_cycles = 3'd0;
    for (int c = 2; c <= 40; c++) begin
      tick();
      check_dark($sformatf("t4z c%0d", c));
    end

    // 5: mid-slot data change is deferred to the next slot of that digit
    do_reset(2);
    d_in = 16'h4321; dp_in = 4'b0000; en = 4'b1111; on_cycles = 3'd7;
    run_to(5);
    d_in[3:0] = 4'h8;
    for (int c = 5; c <= 9; c++) begin
      run_to(c);
      check_lit($sformatf("t5 hold c%0d", c), 4'b0111, 7'h06, 1'b0);
    end
    run_to(36);
    check_lit("t5 new c36", 4'b0111, 7'h7F, 1'b0);
    // Decode sweep: four codes per frame
    do_reset(2);
    dp_in = 4'b0000; en = 4'b1111; on_cycles = 3'd7;
    for (int f = 0; f < 4; f++) begin
      run_to(32 * f + 1);
      for (int k = 0; k < 4; k++) v[4*k +: 4] = 4'(4 * f + k);
      d_in = v;
      for (int k = 0; k < 4; k++) begin
        run_to(32 * f + 8 * k + 4);
        check_lit($sformatf("t5 code %0h", 4 * f + k), ~(4'b1000 >> k), seg_tab[4 * f + k], 1'b0);
      end
    end

    // 6: one-cycle reset mid-slot restarts the scan
    do_reset(2);
    d_in = 16'h4321; dp_in = 4'b0000; en = 4'b1111; on_cycles = 3'd3;
    run_to(22);
    check_lit("t6 pre c22", 4'b1101, 7'h4F, 1'b0);
    rst_n = 1'b0;
    tick();
    check_dark("t6 post rst");
    check("t6 post rst ft", 32'(frame_tick), 32'h0);
    rst_n = 1'b1;
    cyc   = 1;
    for (int c = 2; c <= 33; c++) begin
      tick();
      check($sformatf("t6 ft c%0d", c), 32'(frame_tick), 32'(c == 33));
      if (c == 3 || c == 7) check_dark($sformatf("t6 c%0d", c));
      if (c >= 4 && c <= 6) check_lit($sformatf("t6 c%0d", c), 4'b0111, 7'h06, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
